// File: rtl/cgra_pkg.sv
// Shared CGRA constants: column count, kernel-ID width and the layout of the
// performance-counter index space used by the status unit.
package cgra_pkg;

    localparam int N_COL               = 4;
    localparam int KER_CONF_N_REG_LOG2 = 4;

    // Counter 0 counts launched kernels; each column then owns a busy/stall pair.
    localparam int CNT_IDX_KERNELS  = 0;
    localparam int CNT_IDX_COL_BASE = 1;
    localparam int CNT_PER_COL      = 2;

    typedef logic [KER_CONF_N_REG_LOG2-1:0] ker_id_t;

    function automatic int cnt_idx_busy(input int col);
        return CNT_IDX_COL_BASE + CNT_PER_COL * col;
    endfunction

    function automatic int cnt_idx_stall(input int col);
        return CNT_IDX_COL_BASE + CNT_PER_COL * col + 1;
    endfunction

endpackage

// File: rtl/cgra_perf_status_unit_if.sv
// Bundle of the kernel-launch, column-status and counter-read signals of the
// CGRA performance/status unit; the host side drives the master modport.
interface cgra_perf_status_unit_if
    import cgra_pkg::*;
#(
    parameter int NCol     = N_COL,
    parameter int CntWidth = 32
) (
    input logic clk_i
);

    localparam int IdxW = $clog2(2 * NCol + 1);

    logic                ker_valid;
    ker_id_t             ker_id;
    logic                ker_ready;
    logic                ker_pending;
    ker_id_t             ker_head;
    logic [NCol-1:0]     acc_req;
    logic [NCol-1:0]     acc_end;
    logic [NCol-1:0]     col_stall;
    logic                acc_ack;
    logic [NCol-1:0]     col_status;
    logic                perf_cnt_en;
    logic                perf_cnt_clr;
    logic                snapshot;
    logic [IdxW-1:0]     rd_idx;
    logic                rd_en;
    logic [CntWidth-1:0] rd_data;
    logic                rd_valid;
    logic                err;

    modport master (
        input  clk_i,
        output ker_valid, ker_id, acc_req, acc_end, col_stall, acc_ack,
               perf_cnt_en, perf_cnt_clr, snapshot, rd_idx, rd_en,
        input  ker_ready, ker_pending, ker_head, col_status, rd_data, rd_valid, err
    );

    modport slave (
        input  clk_i,
        input  ker_valid, ker_id, acc_req, acc_end, col_stall, acc_ack,
               perf_cnt_en, perf_cnt_clr, snapshot, rd_idx, rd_en,
        output ker_ready, ker_pending, ker_head, col_status, rd_data, rd_valid, err
    );

endinterface

// File: rtl/cgra_perf_cnt.sv
// One performance counter: a live count plus a shadow copy captured on
// snapshot. Clear has priority over both increment and snapshot.
module cgra_perf_cnt #(
    parameter int CntWidth = 32,
    parameter int SatMode  = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic                snap_i,
    output logic [CntWidth-1:0] shadow_o
);

    localparam logic [CntWidth-1:0] CntMax = '1;

    logic [CntWidth-1:0] r_live;
    logic [CntWidth-1:0] r_shadow;
    logic [CntWidth-1:0] w_live_nxt;

    // Next live value on increment: hold or wrap at the top of the range.
    always_comb begin
        w_live_nxt = r_live + CntWidth'(1);
        if (r_live == CntMax) begin
            w_live_nxt = (SatMode != 0) ? CntMax : '0;
        end
    end

    // Live/shadow update; the shadow captures the value before this cycle's increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_live   <= '0;
            r_shadow <= '0;
        end else if (clr_i) begin
            r_live   <= '0;
            r_shadow <= '0;
        end else begin
            if (en_i) begin
                r_live <= w_live_nxt;
            end
            if (snap_i) begin
                r_shadow <= r_live;
            end
        end
    end

    assign shadow_o = r_shadow;

endmodule

// File: rtl/cgra_perf_status_unit.sv
// CGRA performance/status unit: kernel-launch FIFO, per-column busy tracking,
// a bank of 2*NCol+1 snapshot-able performance counters and a registered
// counter read port.
module cgra_perf_status_unit
    import cgra_pkg::*;
#(
    parameter int NCol     = N_COL,
    parameter int CntWidth = 32,
    parameter int QDepth   = 4,
    parameter int SatMode  = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           ker_valid_i,
    input  logic [KER_CONF_N_REG_LOG2-1:0] ker_id_i,
    output logic                           ker_ready_o,
    output logic                           ker_pending_o,
    output logic [KER_CONF_N_REG_LOG2-1:0] ker_id_o,
    input  logic [NCol-1:0]                acc_req_i,
    input  logic [NCol-1:0]                acc_end_i,
    input  logic [NCol-1:0]                col_stall_i,
    input  logic                           acc_ack_i,
    output logic [NCol-1:0]                col_status_o,
    input  logic                           perf_cnt_en_i,
    input  logic                           perf_cnt_clr_i,
    input  logic                           snapshot_i,
    input  logic [$clog2(2*NCol+1)-1:0]    rd_idx_i,
    input  logic                           rd_en_i,
    output logic [CntWidth-1:0]            rd_data_o,
    output logic                           rd_valid_o,
    output logic                           err_o
);

    localparam int NCnt = 2 * NCol + 1;
    localparam int IdxW = $clog2(2 * NCol + 1);
    localparam int PtrW = $clog2(QDepth);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    ker_id_t             r_queue [QDepth];
    logic [PtrW:0]       r_wptr;
    logic [PtrW:0]       r_rptr;
    logic [NCol-1:0]     r_col_status;
    logic                r_err;
    logic [CntWidth-1:0] r_rd_data;
    logic                r_rd_valid;

    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [NCnt-1:0]     w_cnt_inc;
    logic [CntWidth-1:0] w_shadow [NCnt];
    logic [CntWidth-1:0] w_rd_sel;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PtrW] != r_rptr[PtrW]) &&
                     (r_wptr[PtrW-1:0] == r_rptr[PtrW-1:0]);
    // A full queue refuses a push even when a pop happens in the same cycle.
    assign w_push  = ker_valid_i && !w_full;
    assign w_pop   = acc_ack_i && !w_empty;

    assign ker_ready_o   = !w_full;
    assign ker_pending_o = !w_empty;
    assign ker_id_o      = w_empty ? '0 : r_queue[r_rptr[PtrW-1:0]];

    // Launch FIFO storage and pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < QDepth; k++) begin
                r_queue[k] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_queue[r_wptr[PtrW-1:0]] <= ker_id_i;
                r_wptr                    <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Sticky error on an accept with nothing queued; only clear or reset drop it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (perf_cnt_clr_i) begin
            r_err <= 1'b0;
        end else if (acc_ack_i && w_empty) begin
            r_err <= 1'b1;
        end
    end

    // Column busy state: a new request on accept wins over an end on the same bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_col_status <= '0;
        end else begin
            r_col_status <= (r_col_status & ~acc_end_i) | (acc_ack_i ? acc_req_i : '0);
        end
    end

    assign col_status_o = r_col_status;

    // Increment conditions for every counter in the bank.
    always_comb begin
        w_cnt_inc = '0;
        w_cnt_inc[CNT_IDX_KERNELS] = perf_cnt_en_i && w_pop;
        for (int c = 0; c < NCol; c++) begin
            w_cnt_inc[cnt_idx_busy(c)]  = perf_cnt_en_i && (r_col_status[c] || acc_req_i[c]);
            w_cnt_inc[cnt_idx_stall(c)] = perf_cnt_en_i && col_stall_i[c];
        end
    end

    for (genvar g = 0; g < NCnt; g++) begin : g_cnt
        cgra_perf_cnt #(
            .CntWidth (CntWidth),
            .SatMode  (SatMode)
        ) u_cnt (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .clr_i    (perf_cnt_clr_i),
            .en_i     (w_cnt_inc[g]),
            .snap_i   (snapshot_i),
            .shadow_o (w_shadow[g])
        );
    end

    // Shadow select; indices beyond the bank read as zero.
    always_comb begin
        w_rd_sel = '0;
        for (int k = 0; k < NCnt; k++) begin
            if (rd_idx_i == IdxW'(k)) begin
                w_rd_sel = w_shadow[k];
            end
        end
    end

    // Registered read port: result and valid appear one cycle after the strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en_i;
            if (rd_en_i) begin
                r_rd_data <= w_rd_sel;
            end
        end
    end

    assign rd_data_o  = r_rd_data;
    assign rd_valid_o = r_rd_valid;
    assign err_o      = r_err;

endmodule

// File: tb/tb_cgra_perf_status_unit.sv
// Bench for cgra_perf_status_unit: two instances (4-bit counters, saturating
// and wrapping) share one stimulus bus and are compared each cycle against a
// queue/unbounded-count reference model, plus directed corner sequences.
module tb_cgra_perf_status_unit;
    import cgra_pkg::*;

    localparam int NC   = N_COL;
    localparam int CW   = 4;
    localparam int QD   = 4;
    localparam int NCNT = 2 * NC + 1;
    localparam int IW   = $clog2(2 * NC + 1);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cgra_perf_status_unit_if #(.NCol(NC), .CntWidth(CW)) bus (.clk_i(clk));

    logic            b_ready, b_pending, b_rvld, b_err;
    ker_id_t         b_head;
    logic [NC-1:0]   b_cs;
    logic [CW-1:0]   b_rdata;

    cgra_perf_status_unit #(.NCol(NC), .CntWidth(CW), .QDepth(QD), .SatMode(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .ker_valid_i(bus.ker_valid), .ker_id_i(bus.ker_id),
        .ker_ready_o(bus.ker_ready), .ker_pending_o(bus.ker_pending), .ker_id_o(bus.ker_head),
        .acc_req_i(bus.acc_req), .acc_end_i(bus.acc_end), .col_stall_i(bus.col_stall),
        .acc_ack_i(bus.acc_ack), .col_status_o(bus.col_status),
        .perf_cnt_en_i(bus.perf_cnt_en), .perf_cnt_clr_i(bus.perf_cnt_clr), .snapshot_i(bus.snapshot),
        .rd_idx_i(bus.rd_idx), .rd_en_i(bus.rd_en),
        .rd_data_o(bus.rd_data), .rd_valid_o(bus.rd_valid), .err_o(bus.err)
    );

    cgra_perf_status_unit #(.NCol(NC), .CntWidth(CW), .QDepth(QD), .SatMode(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .ker_valid_i(bus.ker_valid), .ker_id_i(bus.ker_id),
        .ker_ready_o(b_ready), .ker_pending_o(b_pending), .ker_id_o(b_head),
        .acc_req_i(bus.acc_req), .acc_end_i(bus.acc_end), .col_stall_i(bus.col_stall),
        .acc_ack_i(bus.acc_ack), .col_status_o(b_cs),
        .perf_cnt_en_i(bus.perf_cnt_en), .perf_cnt_clr_i(bus.perf_cnt_clr), .snapshot_i(bus.snapshot),
        .rd_idx_i(bus.rd_idx), .rd_en_i(bus.rd_en),
        .rd_data_o(b_rdata), .rd_valid_o(b_rvld), .err_o(b_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of IDs, unbounded event counts folded at read time.
    int            mq[$];
    logic [NC-1:0] m_cs;
    bit            m_err;
    longint        m_live   [NCNT];
    longint        m_shadow [NCNT];
    bit            m_rvld;
    longint        m_rval;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A saturating counter shows min(count, max); a wrapping one shows count mod 2^CW.
    function automatic logic [63:0] fold(input longint v, input bit sat);
        longint top = (longint'(1) << CW) - 1;
        if (sat) return (v > top) ? top : v;
        return v % (top + 1);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_cs   = '0;
        m_err  = 1'b0;
        m_rvld = 1'b0;
        m_rval = 0;
        for (int k = 0; k < NCNT; k++) begin
            m_live[k]   = 0;
            m_shadow[k] = 0;
        end
    endtask

    task automatic model_step();
        bit     empty, full, pop, push, en;
        longint inc [NCNT];
        empty = (mq.size() == 0);
        full  = (mq.size() == QD);
        pop   = bus.acc_ack && !empty;
        push  = bus.ker_valid && !full;
        en    = bus.perf_cnt_en;
        for (int k = 0; k < NCNT; k++) inc[k] = 0;
        inc[CNT_IDX_KERNELS] = (en && pop) ? 1 : 0;
        for (int c = 0; c < NC; c++) begin
            inc[cnt_idx_busy(c)]  = (en && (m_cs[c] || bus.acc_req[c])) ? 1 : 0;
            inc[cnt_idx_stall(c)] = (en && bus.col_stall[c]) ? 1 : 0;
        end
        if (bus.rd_en) begin
            m_rvld = 1'b1;
            m_rval = (int'(bus.rd_idx) < NCNT) ? m_shadow[bus.rd_idx] : 0;
        end else begin
            m_rvld = 1'b0;
        end
        if (bus.perf_cnt_clr) begin
            for (int k = 0; k < NCNT; k++) begin
                m_live[k]   = 0;
                m_shadow[k] = 0;
            end
            m_err = 1'b0;
        end else begin
            for (int k = 0; k < NCNT; k++) begin
                if (bus.snapshot) m_shadow[k] = m_live[k];
                m_live[k] += inc[k];
            end
            if (bus.acc_ack && empty) m_err = 1'b1;
        end
        m_cs = (m_cs & ~bus.acc_end) | (bus.acc_ack ? bus.acc_req : '0);
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(int'(bus.ker_id));
    endtask

    task automatic compare_all();
        check("ready",   bus.ker_ready,   mq.size() < QD);
        check("pending", bus.ker_pending, mq.size() > 0);
        check("head",    bus.ker_head,    (mq.size() > 0) ? mq[0] : 0);
        check("col",     bus.col_status,  m_cs);
        check("err",     bus.err,         m_err);
        check("rvld",    bus.rd_valid,    m_rvld);
        check("b_head",  b_head,          (mq.size() > 0) ? mq[0] : 0);
        check("b_flags", {b_ready, b_pending, b_err}, {mq.size() < QD, mq.size() > 0, m_err});
        check("b_col",   b_cs,            m_cs);
        check("b_rvld",  b_rvld,          m_rvld);
        if (m_rvld) begin
            check("rdata_sat",  bus.rd_data, fold(m_rval, 1'b1));
            check("rdata_wrap", b_rdata,     fold(m_rval, 1'b0));
        end
    endtask

    task automatic idle();
        bus.ker_valid = 0; bus.ker_id = '0; bus.acc_req = '0; bus.acc_end = '0;
        bus.col_stall = '0; bus.acc_ack = 0; bus.perf_cnt_en = 0; bus.perf_cnt_clr = 0;
        bus.snapshot = 0; bus.rd_idx = '0; bus.rd_en = 0;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit      valid;
        ker_id_t id;
        bit      ack;
        bit      exp_ready;
        bit      exp_pend;
        ker_id_t exp_head;
    } qvec_t;

    qvec_t qtab [9];

    initial begin
        qtab[0] = '{1, 4'd3, 0, 1, 1, 4'd3};
        qtab[1] = '{1, 4'd5, 0, 1, 1, 4'd3};
        qtab[2] = '{1, 4'd7, 0, 1, 1, 4'd3};
        qtab[3] = '{1, 4'd1, 0, 0, 1, 4'd3};
        qtab[4] = '{1, 4'd2, 0, 0, 1, 4'd3};
        qtab[5] = '{0, 4'd0, 1, 1, 1, 4'd5};
        qtab[6] = '{0, 4'd0, 1, 1, 1, 4'd7};
        qtab[7] = '{0, 4'd0, 1, 1, 1, 4'd1};
        qtab[8] = '{0, 4'd0, 1, 1, 0, 4'd0};

        idle();
        rst_n = 1'b0;
        model_reset();
        #12;
        // Reset state
        check("rst_ready",   bus.ker_ready, 1);
        check("rst_pending", bus.ker_pending, 0);
        check("rst_head",    bus.ker_head, 0);
        check("rst_col",     bus.col_status, 0);
        check("rst_err",     bus.err, 0);
        check("rst_rvld",    bus.rd_valid, 0);
        check("rst_rdata",   bus.rd_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // FIFO fill/overflow/drain table
        for (int i = 0; i < 9; i++) begin
            bus.ker_valid = qtab[i].valid;
            bus.ker_id    = qtab[i].id;
            bus.acc_ack   = qtab[i].ack;
            cyc();
            check("tab_ready", bus.ker_ready,   qtab[i].exp_ready);
            check("tab_pend",  bus.ker_pending, qtab[i].exp_pend);
            check("tab_head",  bus.ker_head,    qtab[i].exp_head);
        end
        idle();

        // Busy counter over an 11-cycle column activity window
        do_reset();
        bus.ker_valid = 1; bus.ker_id = 4'd9; cyc(); idle();
        bus.perf_cnt_en = 1;
        bus.acc_req = 4'b0001; bus.acc_ack = 1; cyc();
        check("busy_set", bus.col_status, 4'b0001);
        bus.acc_req = '0; bus.acc_ack = 0;
        repeat (9) cyc();
        bus.acc_end = 4'b0001; cyc(); bus.acc_end = '0;
        check("busy_end", bus.col_status, 4'b0000);
        bus.snapshot = 1; cyc(); bus.snapshot = 0;
        bus.rd_en = 1; bus.rd_idx = IW'(1); cyc();
        check("busy_vld", bus.rd_valid, 1);
        check("busy_cnt", bus.rd_data, 11);
        bus.rd_idx = IW'(0); cyc();
        check("kern_cnt", bus.rd_data, 1);
        idle();

        // Saturate vs wrap of a stall counter
        bus.perf_cnt_clr = 1; cyc(); bus.perf_cnt_clr = 0;
        bus.perf_cnt_en = 1; bus.col_stall = 4'b0001;
        repeat (20) cyc();
        bus.col_stall = '0; bus.snapshot = 1; cyc(); bus.snapshot = 0;
        bus.rd_en = 1; bus.rd_idx = IW'(2); cyc();
        check("stall_sat",  bus.rd_data, 15);
        check("stall_wrap", b_rdata, 4);
        idle();

        // Set wins over end on the same column; other columns independent
        bus.ker_valid = 1; bus.ker_id = 4'd4; cyc(); bus.ker_id = 4'd6; cyc(); idle();
        bus.acc_ack = 1; bus.acc_req = 4'b0011; cyc();
        bus.acc_req = 4'b0010; bus.acc_end = 4'b0011; cyc();
        check("setwins_c1", bus.col_status[1], 1);
        check("setwins_c0", bus.col_status[0], 0);
        idle();
        bus.acc_end = 4'b0010; cyc(); idle();
        check("end_c1", bus.col_status, 0);

        // Accept on an empty queue, then clear
        do_reset();
        bus.perf_cnt_en = 1; bus.col_stall = 4'b1111;
        repeat (3) cyc();
        bus.col_stall = '0; bus.acc_ack = 1; cyc(); bus.acc_ack = 0;
        check("err_set", bus.err, 1);
        bus.snapshot = 1; cyc(); bus.snapshot = 0;
        bus.rd_en = 1; bus.rd_idx = IW'(0); cyc();
        check("err_kern0", bus.rd_data, 0);
        bus.rd_idx = IW'(2); cyc();
        check("err_stall", bus.rd_data, 3);
        bus.rd_en = 0; bus.perf_cnt_clr = 1; cyc(); bus.perf_cnt_clr = 0;
        check("err_clr", bus.err, 0);
        bus.rd_en = 1;
        for (int k = 0; k < NCNT; k++) begin
            bus.rd_idx = IW'(k); cyc();
            check("clr_read", bus.rd_data, 0);
        end
        bus.snapshot = 1; bus.rd_idx = IW'(0); cyc(); bus.snapshot = 0;
        bus.rd_idx = IW'(2); cyc();
        check("resnap_stall", bus.rd_data, 0);
        bus.rd_idx = IW'(NCNT); cyc();
        check("oob_vld",  bus.rd_valid, 1);
        check("oob_data", bus.rd_data, 0);
        idle();

        // Asynchronous reset in the middle of a read
        do_reset();
        bus.ker_valid = 1; bus.ker_id = 4'd2; cyc(); bus.ker_id = 4'd8; cyc(); idle();
        bus.acc_ack = 1; bus.acc_req = 4'b0100; cyc(); idle();
        bus.rd_en = 1; bus.rd_idx = IW'(1); cyc();
        check("pre_rst_vld", bus.rd_valid, 1);
        bus.rd_en = 0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_vld",  bus.rd_valid, 0);
        check("mid_rst_pend", bus.ker_pending, 0);
        check("mid_rst_col",  bus.col_status, 0);
        check("mid_rst_head", bus.ker_head, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            bus.ker_valid    = ($urandom_range(0, 1) == 1);
            bus.ker_id       = ker_id_t'($urandom_range(0, 15));
            bus.acc_ack      = ($urandom_range(0, 99) < 35);
            bus.acc_req      = NC'($urandom_range(0, 15));
            bus.acc_end      = NC'($urandom_range(0, 15) & $urandom_range(0, 15));
            bus.col_stall    = NC'($urandom_range(0, 15));
            bus.perf_cnt_en  = ($urandom_range(0, 99) < 85);
            bus.perf_cnt_clr = ($urandom_range(0, 99) < 3);
            bus.snapshot     = ($urandom_range(0, 99) < 15);
            bus.rd_en        = ($urandom_range(0, 1) == 1);
            bus.rd_idx       = IW'($urandom_range(0, 15));
            cyc();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cgra_perf_status_unit.md
CGRA_PERF_STATUS_UNIT -- requirements
Module: cgra_perf_status_unit

Interface
REQ-001 SHALL have parameter NCol, default N_COL; number of CGRA columns monitored.
REQ-002 SHALL have parameter CntWidth, default 32; width of every performance counter.
REQ-003 SHALL have parameter QDepth, default 4 (power of two, >=2); kernel-launch queue depth.
REQ-004 SHALL have parameter SatMode, default 1; 1 = counters saturate, 0 = counters wrap.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port ker_valid_i, input, 1 bit: kernel launch request.
REQ-008 SHALL have port ker_id_i, input, KER_CONF_N_REG_LOG2 bits: kernel ID to enqueue.
REQ-009 SHALL have port ker_ready_o, output, 1 bit: queue can accept a launch.
REQ-010 SHALL have port ker_pending_o, output, 1 bit: queue not empty.
REQ-011 SHALL have port ker_id_o, output, KER_CONF_N_REG_LOG2 bits: queue head ID, 0 when empty.
REQ-012 SHALL have ports acc_req_i, acc_end_i and col_stall_i, each input, NCol bits: per-column request, end and stall.
REQ-013 SHALL have port acc_ack_i, input, 1 bit: launch accepted by the CGRA.
REQ-014 SHALL have port col_status_o, output, NCol bits: 1 = column busy.
REQ-015 SHALL have ports perf_cnt_en_i, perf_cnt_clr_i and snapshot_i, each input, 1 bit: count enable, clear pulse, snapshot pulse.
REQ-016 SHALL have port rd_idx_i, input, $clog2(2*NCol+1) bits: counter select.
REQ-017 SHALL have port rd_en_i, input, 1 bit: read strobe.
REQ-018 SHALL have ports rd_data_o, output, CntWidth bits, and rd_valid_o, output, 1 bit: registered read result.
REQ-019 SHALL have port err_o, output, 1 bit: sticky flag, acc_ack_i while queue empty.

Function
REQ-020 Queue SHALL be a FIFO; push on ker_valid_i&ker_ready_o; ker_ready_o = !full (full blocks push even if pop same cycle); pop on acc_ack_i when not empty; simultaneous push+pop when neither full nor empty keeps occupancy.
REQ-021 acc_ack_i with empty queue SHALL not pop, SHALL set err_o; err_o clears only on reset or perf_cnt_clr_i.
REQ-022 col_status next SHALL be (col_status & ~acc_end_i) | (acc_ack_i ? acc_req_i : 0); set wins over end on the same bit, other columns updated independently.
REQ-023 Counter 0 (total kernels) SHALL increment on perf_cnt_en_i & acc_ack_i & !empty.
REQ-024 Counter 1+2c SHALL increment on perf_cnt_en_i & (col_status[c] | acc_req_i[c]); counter 2+2c on perf_cnt_en_i & col_stall_i[c].
REQ-025 At max value SHALL hold when SatMode=1, wrap to 0 when SatMode=0.
REQ-026 perf_cnt_clr_i SHALL zero all live counters and shadows next cycle, overriding increments.
REQ-027 snapshot_i SHALL copy live counters (pre-increment value of that cycle) into shadows; clear overrides snapshot.
REQ-028 rd_en_i SHALL, one cycle later, give rd_valid_o=1 with the shadow selected by rd_idx_i; index > 2*NCol SHALL return 0 with rd_valid_o=1.

Reset
REQ-029 Reset SHALL zero queue, pointers, col_status_o, counters, shadows, rd_data_o, rd_valid_o, err_o; ker_ready_o=1, ker_pending_o=0, ker_id_o=0.
REQ-030 Reset asserted mid-operation SHALL discard queued IDs and in-flight reads immediately.

Structure
REQ-031 N_COL, KER_CONF_N_REG_LOG2 and counter index constants SHALL come from cgra_pkg.
REQ-032 One sub-module cgra_perf_cnt (clr/en/snap, SatMode, live+shadow) SHALL be instantiated 2*NCol+1 times.

Verification
REQ-033 Push IDs 3,5,7,1,2 with no ack (QDepth=4) -> ker_ready_o=0 after 4th, 5th ignored, head=3; four acks yield 3,5,7,1.
REQ-034 acc_req_i=0001, ack, 10 cycles, acc_end_i=0001, en=1, snapshot, read idx 1 -> 11.
REQ-035 CntWidth=4, SatMode=1, stall col0 20 cycles -> idx 2 reads 15; SatMode=0 -> reads 4.
REQ-036 Same cycle ack with req=0010 and end=0010 while col1 busy -> col_status_o[1]=1.
REQ-037 Ack on empty queue -> err_o=1, counter 0 unchanged; clr -> err_o=0, all reads 0; rd_idx_i=2*NCol+1 -> 0.
REQ-038 Reset mid-read after 2 pushes -> rd_valid_o=0, ker_pending_o=0, col_status_o=0.
